// File: rtl/cam_capture.sv
// Camera frame capture: samples an OV7670-style byte bus, assembles RGB565
// pixels and writes one H_RES x V_RES frame into a RAM write port from address 0.
module cam_capture #(
  parameter int H_RES = 160,
  parameter int V_RES = 120,
  parameter int AW    = 15,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_wr,
  output logic          busy,
  output logic          frame_done,
  output logic          err
);

  localparam int CW = $clog2(H_RES + 1);
  localparam int LW = $clog2(V_RES + 1);
  localparam int PW = AW + 1;
  localparam logic [CW-1:0] COL_MAX   = CW'(H_RES);
  localparam logic [LW-1:0] LINE_MAX  = LW'(V_RES);
  localparam logic [PW-1:0] PIX_TOTAL = PW'(H_RES * V_RES);

  generate
    if (H_RES * V_RES > 2 ** AW) begin : g_geom_chk
      $error("cam_capture: H_RES*V_RES does not fit in 2**AW addresses");
    end
    if (DW != 16) begin : g_dw_chk
      $error("cam_capture: DW must be 16 (RGB565)");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_VS    = 3'd1,
    WAIT_FRAME = 3'd2,
    CAPTURE    = 3'd3,
    DONE       = 3'd4
  } state_t;

  state_t        state;
  logic          vs_d;
  logic          hr_d;
  logic          phase;
  logic [7:0]    hi_byte;
  logic [CW-1:0] col;
  logic [LW-1:0] line;
  logic [PW-1:0] pix_cnt;

  logic vs_rise;
  logic vs_fall;
  assign vs_rise = vsync & ~vs_d;
  assign vs_fall = ~vsync & vs_d;

  // Write port: mem_wr is a one-cycle strobe with mem_addr/mem_data valid in the
  // same cycle; the RAM always accepts, so there is no ready and no stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vs_d       <= 1'b0;
      hr_d       <= 1'b0;
      phase      <= 1'b0;
      hi_byte    <= 8'h00;
      col        <= '0;
      line       <= '0;
      pix_cnt    <= '0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_wr     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      vs_d       <= vsync;
      hr_d       <= href;
      mem_wr     <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= WAIT_VS;
            busy  <= 1'b1;
            err   <= 1'b0;
          end
        end
        WAIT_VS: begin
          // Waiting for blanking first keeps a frame already in flight out of RAM.
          if (vsync) state <= WAIT_FRAME;
        end
        WAIT_FRAME: begin
          if (vs_fall) begin
            state   <= CAPTURE;
            pix_cnt <= '0;
            col     <= '0;
            line    <= '0;
            phase   <= 1'b0;
          end
        end
        CAPTURE: begin
          if (vs_rise) begin
            // Frame end wins over any byte or line end in the same cycle.
            state      <= DONE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            phase      <= 1'b0;
            if (pix_cnt < PIX_TOTAL) err <= 1'b1;
          end else if (href) begin
            if (!phase) begin
              hi_byte <= px_data;
              phase   <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (col < COL_MAX && line < LINE_MAX) begin
                mem_wr   <= 1'b1;
                mem_addr <= pix_cnt[AW-1:0];
                mem_data <= {hi_byte, px_data};
                pix_cnt  <= pix_cnt + 1'b1;
              end else begin
                err <= 1'b1;
              end
              // Column keeps counting past H_RES (saturating) so clipping is seen.
              if (col != COL_MAX) col <= col + 1'b1;
            end
          end else if (hr_d) begin
            if (line != LINE_MAX) line <= line + 1'b1;
            col   <= '0;
            phase <= 1'b0;
            if (phase) err <= 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state <= WAIT_VS;
            busy  <= 1'b1;
            err   <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture on a 4x2 frame: a frame-level model builds the
// expected RAM writes; one compare process checks every strobe against it.
module tb_cam_capture;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = 15;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          vsync;
  logic          href;
  logic [7:0]    px_data;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_wr;
  logic          busy;
  logic          frame_done;
  logic          err;

  cam_capture #(.H_RES(H), .V_RES(V), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .vsync      (vsync),
    .href       (href),
    .px_data    (px_data),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_wr     (mem_wr),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int fd_count = 0;
  logic prev_wr = 1'b0;

  logic [AW+DW-1:0] exp_q[$];
  int   lens[0:3];
  int   n_lines;
  logic exp_err;
  logic err_after_line[0:3];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame model: bytes numbered from first_byte across the frame, pairs form
  // pixels per line, orphans dropped, pixels outside the window clipped.
  task automatic model_frame(input int first_byte);
    int addr;
    int b;
    logic [7:0] hi;
    logic [7:0] lo;
    addr    = 0;
    b       = first_byte;
    exp_err = 1'b0;
    for (int l = 0; l < n_lines; l++) begin
      if (lens[l] % 2 != 0) exp_err = 1'b1;
      for (int p = 0; p < lens[l] / 2; p++) begin
        hi = 8'(b + 2 * p);
        lo = 8'(b + 2 * p + 1);
        if (p < H && l < V) begin
          exp_q.push_back({AW'(addr), hi, lo});
          addr++;
        end else begin
          exp_err = 1'b1;
        end
      end
      b += lens[l];
      err_after_line[l] = exp_err;
    end
    if (addr < H * V) exp_err = 1'b1;
  endtask

  // driver: optional start, blanking, lines, vsync rise; checks frame end
  task automatic run_frame(input int first_byte, input bit send_start, input bit start_in_done);
    int b;
    b = first_byte;
    if (send_start) begin
      start = 1'b1;
      vsync = 1'b0;
      tick();
      start = 1'b0;
    end
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (2) tick();
    for (int l = 0; l < n_lines; l++) begin
      for (int i = 0; i < lens[l]; i++) begin
        href    = 1'b1;
        px_data = 8'(b);
        b++;
        tick();
      end
      href = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("err_after_line", 32'(err), 32'(err_after_line[l]));
      check("busy_in_capture", 32'(busy), 1);
    end
    vsync = 1'b1;
    tick();
    @(negedge clk);
    check("frame_done_high", 32'(frame_done), 1);
    check("busy_at_done", 32'(busy), 0);
    check("err_at_done", 32'(err), 32'(exp_err));
    check("writes_outstanding", 32'(exp_q.size()), 0);
    if (start_in_done) begin
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("err_cleared_by_start", 32'(err), 0);
      check("busy_after_rearm", 32'(busy), 1);
    end else begin
      tick();
    end
    check("frame_done_one_cycle", 32'(frame_done), 0);
  endtask

  // scoreboard: every strobe must match the head of the expected queue
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (mem_wr) begin
      check("wr_spacing", 32'(prev_wr), 0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_wr got addr %0h data %0h want no write", mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e[AW+DW-1:DW]));
        check("wr_data", 32'(mem_data), 32'(e[DW-1:0]));
      end
    end
    prev_wr = mem_wr;
    if (frame_done) fd_count++;
  end

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    vsync   = 1'b0;
    href    = 1'b0;
    px_data = 8'h00;
    repeat (2) tick();
    @(negedge clk);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_data", 32'(mem_data), 0);
    check("rst_mem_wr", 32'(mem_wr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // nominal frame
    n_lines = 2; lens[0] = 8; lens[1] = 8;
    model_frame(8'h00);
    check("model_nom_size", 32'(exp_q.size()), 8);
    check("model_nom_first", 32'(exp_q[0]), 32'({15'd0, 16'h0001}));
    check("model_nom_last", 32'(exp_q[7]), 32'({15'd7, 16'h0E0F}));
    run_frame(8'h00, 1'b1, 1'b0);

    // mid-frame start: arm while a line is streaming with vsync low
    vsync = 1'b0;
    for (int i = 0; i < 6; i++) begin
      href    = 1'b1;
      px_data = 8'(8'hF0 + i);
      start   = (i == 2);
      tick();
    end
    start = 1'b0;
    href  = 1'b0;
    repeat (2) tick();
    check("busy_after_midframe_start", 32'(busy), 1);
    n_lines = 2; lens[0] = 8; lens[1] = 8;
    model_frame(8'h20);
    run_frame(8'h20, 1'b0, 1'b0);

    // odd line
    n_lines = 2; lens[0] = 7; lens[1] = 8;
    model_frame(8'h40);
    check("model_odd_size", 32'(exp_q.size()), 7);
    check("model_odd_addr2", 32'(exp_q[2]), 32'({15'd2, 16'h4445}));
    check("model_odd_addr3", 32'(exp_q[3]), 32'({15'd3, 16'h4748}));
    run_frame(8'h40, 1'b1, 1'b0);

    // overlong geometry
    n_lines = 3; lens[0] = 10; lens[1] = 10; lens[2] = 10;
    model_frame(8'h60);
    check("model_long_size", 32'(exp_q.size()), 8);
    check("model_long_line1", 32'(exp_q[4]), 32'({15'd4, 16'h6A6B}));
    check("model_long_last", 32'(exp_q[7]), 32'({15'd7, 16'h7071}));
    run_frame(8'h60, 1'b1, 1'b0);

    // short frame, then re-arm in DONE
    n_lines = 1; lens[0] = 8;
    model_frame(8'h90);
    check("model_short_size", 32'(exp_q.size()), 4);
    check("model_short_err", 32'(exp_err), 1);
    run_frame(8'h90, 1'b1, 1'b1);

    // frame captured from the DONE re-arm
    n_lines = 2; lens[0] = 8; lens[1] = 8;
    model_frame(8'hA0);
    run_frame(8'hA0, 1'b0, 1'b0);

    // reset between high and low byte of pixel 2
    n_lines = 1; lens[0] = 4;
    model_frame(8'h00);
    start = 1'b1;
    tick();
    start = 1'b0;
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 5; i++) begin
      href    = 1'b1;
      px_data = 8'(i);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem_wr", 32'(mem_wr), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_mem_addr", 32'(mem_addr), 0);
    check("rst_mid_mem_data", 32'(mem_data), 0);
    check("rst_mid_writes_left", 32'(exp_q.size()), 0);
    repeat (3) begin
      href = ~href;
      tick();
    end
    rst_n = 1'b1;
    href  = 1'b0;
    tick();
    // a full frame with no start must produce nothing
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (2) tick();
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 8; i++) begin
        href    = 1'b1;
        px_data = 8'(8'hB0 + i);
        tick();
      end
      href = 1'b0;
      repeat (3) tick();
    end
    vsync = 1'b1;
    tick();
    @(negedge clk);
    check("unarmed_busy", 32'(busy), 0);
    check("unarmed_frame_done", 32'(frame_done), 0);
    check("unarmed_err", 32'(err), 0);
    tick();

    // recovery frame after reset
    n_lines = 2; lens[0] = 8; lens[1] = 8;
    model_frame(8'hC0);
    run_frame(8'hC0, 1'b1, 1'b0);

    repeat (3) tick();
    check("frame_done_count", 32'(fd_count), 7);
    check("final_writes_left", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
